// File: rtl/sv32_ptw.sv
// -----------------------------------------------------------------------------
// sv32_ptw -- Sv32 hardware page-table walker
//
// On a TLB miss the MMU hands over the faulting virtual address together with
// satp. The walker reads the level-1 PTE and, if that PTE points to another
// table, the level-0 PTE. It then returns the leaf PTE or a structural fault.
// Only one 32-bit PTE read is outstanding at a time. Permission checks
// (R/W/X/U, A/D) are left to the MMU, and the walker never writes PTEs.
//
// Ports
//   clk_i, rst_i          clock and synchronous active-high reset
//   req_valid_i/ready_o   walk request from the MMU (ready only when idle)
//   req_vaddr_i           faulting virtual address
//   satp_i                MODE=[31], root PPN=[21:0]; sampled when a request
//                         is accepted
//   rsp_valid_o           one-cycle result pulse
//   rsp_data_o            [31:0] PTE, [32] superpage, [33] page fault,
//                         [34] access fault, [63:35] zero; holds its value
//                         until the next request is accepted
//   mem_req_valid_o/ready_i/addr_o   PTE read request (physical address)
//   mem_rsp_valid_i/data_i/err_i     PTE read response; err qualified by valid
// -----------------------------------------------------------------------------
module sv32_ptw #(
  parameter int unsigned PTW_TIMEOUT_CYCLES = 256,
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned PADDR_WIDTH        = 34
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [ADDR_WIDTH-1:0]  req_vaddr_i,
  input  logic [31:0]            satp_i,
  output logic                   rsp_valid_o,
  output logic [63:0]            rsp_data_o,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic [PADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                   mem_rsp_valid_i,
  input  logic [31:0]            mem_rsp_data_i,
  input  logic                   mem_rsp_err_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1_REQ,
    S_L1_WAIT,
    S_L0_REQ,
    S_L0_WAIT,
    S_RSP,
    S_DRAIN
  } state_e;

  localparam int unsigned    CNT_W    = $clog2(PTW_TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PTW_TIMEOUT_CYCLES - 1);

  // PTE bit positions
  localparam int unsigned PTE_V = 0;
  localparam int unsigned PTE_R = 1;
  localparam int unsigned PTE_W = 2;
  localparam int unsigned PTE_X = 3;

  state_e           state_q, state_d;
  logic [9:0]       vpn1_q, vpn1_d;       // VA[31:22]
  logic [9:0]       vpn0_q, vpn0_d;       // VA[21:12]
  logic [21:0]      root_ppn_q, root_ppn_d;
  logic [31:0]      pte_q, pte_d;
  logic             super_q, super_d;
  logic             pf_q, pf_d;
  logic             af_q, af_d;
  logic             timed_out_q, timed_out_d;  // RSP must be followed by DRAIN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [33:0]      pte_addr;
  logic             at_l1;
  logic             is_leaf;
  logic             is_bad;

  // Only VA[31:12], satp.MODE and satp.PPN matter to the walk.
  logic unused_inputs;
  assign unused_inputs = ^{req_vaddr_i, satp_i};

  // PTE classification of the response currently on the bus.
  assign at_l1   = (state_q == S_L1_WAIT);
  assign is_bad  = !mem_rsp_data_i[PTE_V] ||
                   (!mem_rsp_data_i[PTE_R] && mem_rsp_data_i[PTE_W]);
  assign is_leaf = mem_rsp_data_i[PTE_R] || mem_rsp_data_i[PTE_X];

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    vpn1_d          = vpn1_q;
    vpn0_d          = vpn0_q;
    root_ppn_d      = root_ppn_q;
    pte_d           = pte_q;
    super_d         = super_q;
    pf_d            = pf_q;
    af_d            = af_q;
    timed_out_d     = timed_out_q;
    cnt_d           = cnt_q;
    req_ready_o     = 1'b0;
    rsp_valid_o     = 1'b0;
    mem_req_valid_o = 1'b0;
    pte_addr        = '0;

    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          vpn1_d      = req_vaddr_i[31:22];
          vpn0_d      = req_vaddr_i[21:12];
          root_ppn_d  = satp_i[21:0];
          pte_d       = '0;
          super_d     = 1'b0;
          af_d        = 1'b0;
          timed_out_d = 1'b0;
          if (satp_i[31]) begin
            pf_d    = 1'b0;
            state_d = S_L1_REQ;
          end else begin
            // Bare mode: the MMU should never have asked for a walk.
            pf_d    = 1'b1;
            state_d = S_RSP;
          end
        end
      end

      S_L1_REQ, S_L0_REQ: begin
        mem_req_valid_o = 1'b1;
        pte_addr = (state_q == S_L1_REQ) ? {root_ppn_q, vpn1_q, 2'b00}
                                         : {pte_q[31:10], vpn0_q, 2'b00};
        if (mem_req_ready_i) begin
          cnt_d   = '0;
          state_d = (state_q == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
        end
      end

      S_L1_WAIT, S_L0_WAIT: begin
        if (mem_rsp_valid_i) begin
          pte_d   = mem_rsp_data_i;
          state_d = S_RSP;
          if (mem_rsp_err_i) begin
            af_d = 1'b1;
          end else if (is_bad) begin
            pf_d = 1'b1;
          end else if (is_leaf) begin
            // A level-1 leaf maps 4 MiB, so PPN[0] must be zero.
            if (at_l1 && (mem_rsp_data_i[19:10] != 10'd0)) begin
              pf_d = 1'b1;
            end else if (at_l1) begin
              super_d = 1'b1;
            end
          end else if (at_l1) begin
            state_d = S_L0_REQ;
          end else begin
            // Pointer at the last level: the table is malformed.
            pf_d = 1'b1;
          end
        end else if (cnt_q == CNT_LAST) begin
          af_d        = 1'b1;
          timed_out_d = 1'b1;
          state_d     = S_RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_RSP: begin
        rsp_valid_o = 1'b1;
        if (timed_out_q) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_DRAIN: begin
        // Swallow the late response of the timed-out read so it cannot be
        // mistaken for the answer to the next walk's read.
        if (mem_rsp_valid_i || (cnt_q == CNT_LAST)) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this clock edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the latched walk data is reset along with the FSM because the
      // result word is visible on rsp_data_o straight out of reset.
      state_q     <= S_IDLE;
      vpn1_q      <= '0;
      vpn0_q      <= '0;
      root_ppn_q  <= '0;
      pte_q       <= '0;
      super_q     <= 1'b0;
      pf_q        <= 1'b0;
      af_q        <= 1'b0;
      timed_out_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      vpn1_q      <= vpn1_d;
      vpn0_q      <= vpn0_d;
      root_ppn_q  <= root_ppn_d;
      pte_q       <= pte_d;
      super_q     <= super_d;
      pf_q        <= pf_d;
      af_q        <= af_d;
      timed_out_q <= timed_out_d;
      cnt_q       <= cnt_d;
    end
  end

  assign mem_req_addr_o = PADDR_WIDTH'(pte_addr);
  assign rsp_data_o     = {29'd0, af_q, pf_q, super_q, pte_q};

endmodule

// File: tb/tb_sv32_ptw.sv
// -----------------------------------------------------------------------------
// tb_sv32_ptw -- self-checking bench for sv32_ptw
//
// One initial block drives directed scenarios followed by randomised walks.
// A sparse memory model answers PTE reads with configurable ready stalls and
// response delays. Expected results for the random walks come from a
// behavioural two-level walk written directly from the Sv32 rules.
// -----------------------------------------------------------------------------
module tb_sv32_ptw;

  localparam int TO = 256;

  logic        clk_i;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_vaddr_i;
  logic [31:0] satp_i;
  logic        rsp_valid_o;
  logic [63:0] rsp_data_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [33:0] mem_req_addr_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rsp_data_i;
  logic        mem_rsp_err_i;

  sv32_ptw #(
    .PTW_TIMEOUT_CYCLES(TO),
    .ADDR_WIDTH        (32),
    .PADDR_WIDTH       (34)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_vaddr_i    (req_vaddr_i),
    .satp_i         (satp_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_data_o     (rsp_data_o),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o (mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_data_i (mem_rsp_data_i),
    .mem_rsp_err_i  (mem_rsp_err_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Counters and check
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Memory model
  // ---------------------------------------------------------------------------
  logic [31:0] mem     [logic [33:0]];
  bit          mem_err [logic [33:0]];

  function automatic logic [31:0] mem_rd(input logic [33:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  int          cyc = 0;
  int          rsp_cnt = 0;
  int          rsp_cyc = 0;
  int          hs_first = 0;
  logic [63:0] rsp_last = '0;
  logic [33:0] reads[$];
  int          cfg_stall = 0;
  int          cfg_delay = 0;
  int          stall_left = 0;
  int          rsp_budget = 1000000;
  bit          pend = 0;
  int          pend_wait = 0;
  logic [33:0] pend_addr = '0;
  bit          hold_active = 0;
  logic [33:0] hold_addr = '0;
  int          stable_err = 0;

  // One clock cycle: observe DUT outputs at the falling edge, then drive the
  // memory side for the next rising edge.
  task automatic tick();
    @(negedge clk_i);
    cyc++;
    if (rsp_valid_o === 1'b1) begin
      rsp_cnt++;
      rsp_last = rsp_data_o;
      rsp_cyc  = cyc;
    end
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = $urandom;
    mem_rsp_err_i   = 1'($urandom);
    if (pend) begin
      if (pend_wait > 0) pend_wait--;
      else begin
        mem_rsp_valid_i = 1'b1;
        mem_rsp_data_i  = mem_rd(pend_addr);
        mem_rsp_err_i   = 1'(mem_err.exists(pend_addr));
        pend = 0;
      end
    end
    if (mem_req_valid_o === 1'b1) begin
      if (hold_active && (mem_req_addr_o !== hold_addr)) stable_err++;
      hold_active = 1;
      hold_addr   = mem_req_addr_o;
      if (stall_left > 0) begin
        mem_req_ready_i = 1'b0;
        stall_left--;
      end else begin
        mem_req_ready_i = 1'b1;
        if (reads.size() == 0) hs_first = cyc;
        reads.push_back(mem_req_addr_o);
        hold_active = 0;
        stall_left  = cfg_stall;
        if (rsp_budget > 0) begin
          pend      = 1;
          pend_wait = cfg_delay;
          pend_addr = mem_req_addr_o;
          rsp_budget--;
        end
      end
    end else begin
      mem_req_ready_i = 1'($urandom);
      hold_active     = 0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference walk: Sv32 translation rules with plain arithmetic
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] ref_walk(input logic [31:0] satp, input logic [31:0] va,
                                           output int n, output logic [33:0] ea0,
                                           output logic [33:0] ea1);
    logic [33:0] base;
    logic [33:0] a;
    logic [31:0] pte;
    logic [9:0]  idx;
    n = 0; ea0 = '0; ea1 = '0;
    if (!satp[31]) return 64'h2_0000_0000;
    base = 34'(satp[21:0]) * 34'd4096;
    for (int lvl = 1; lvl >= 0; lvl--) begin
      idx = (lvl == 1) ? va[31:22] : va[21:12];
      a   = base + 34'(idx) * 34'd4;
      if (n == 0) ea0 = a; else ea1 = a;
      n++;
      pte = mem_rd(a);
      if (mem_err.exists(a))              return {29'd0, 3'b100, pte};
      if (!pte[0] || (!pte[1] && pte[2])) return {29'd0, 3'b010, pte};
      if (pte[1] || pte[3]) begin
        if (lvl == 0)               return {32'd0, pte};
        if (pte[19:10] != 10'd0)    return {29'd0, 3'b010, pte};
        return {29'd0, 3'b001, pte};
      end
      if (lvl == 0) return {29'd0, 3'b010, pte};
      base = 34'(pte[31:10]) * 34'd4096;
    end
    return '0;
  endfunction

  function automatic logic [31:0] gen_pte();
    logic [31:0] p;
    p = $urandom;
    case ($urandom_range(0, 5))
      0:       p[0] = 1'b0;                       // invalid
      1:       p[2:0] = 3'b101;                   // W without R
      2:       begin p[0] = 1'b1; p[1] = 1'b1; end // leaf
      3:       begin p[3:0] = 4'b1011; p[19:10] = '0; end // aligned leaf
      default: begin p[0] = 1'b1; p[3:1] = 3'b000; end    // pointer
    endcase
    return p;
  endfunction

  // ---------------------------------------------------------------------------
  // Walk driver and checker
  // ---------------------------------------------------------------------------
  task automatic walk(input logic [31:0] satp, input logic [31:0] va, input int budget,
                      output logic [63:0] data, output int lat, output int npulse,
                      output logic ready_at_pulse);
    int c0, p0;
    for (int i = 0; i < 20 && req_ready_o !== 1'b1; i++) tick();
    reads.delete();
    stall_left  = cfg_stall;
    hold_active = 0;
    p0 = rsp_cnt;
    c0 = cyc;
    req_valid_i = 1'b1;
    satp_i      = satp;
    req_vaddr_i = va;
    tick();
    req_valid_i = 1'b0;
    satp_i      = $urandom;
    req_vaddr_i = $urandom;
    for (int i = 0; i < budget && rsp_cnt == p0; i++) tick();
    lat = -1; data = 'x; ready_at_pulse = 1'bx;
    if (rsp_cnt != p0) begin
      lat            = rsp_cyc - c0;
      data           = rsp_last;
      ready_at_pulse = req_ready_o;
    end
    tick();
    tick();
    npulse = rsp_cnt - p0;
  endtask

  task automatic walk_chk(input string tag, input logic [31:0] satp, input logic [31:0] va,
                          input logic [63:0] exp, input int exp_lat, input int exp_n,
                          input logic [33:0] ea0, input logic [33:0] ea1, input int budget,
                          output int lat);
    logic [63:0] data;
    int          np;
    logic        rdy;
    stable_err = 0;
    walk(satp, va, budget, data, lat, np, rdy);
    check({tag, ".pulses"}, 64'(np), 64'd1);
    check({tag, ".data"}, data, exp);
    check({tag, ".hold"}, rsp_data_o, exp);
    check({tag, ".ready_at_pulse"}, 64'(rdy), 64'd0);
    check({tag, ".reads"}, 64'(reads.size()), 64'(exp_n));
    if (exp_n > 0)
      check({tag, ".addr_l1"}, (reads.size() > 0) ? reads[0] : 34'h3_FFFF_FFFF, 64'(ea0));
    if (exp_n > 1)
      check({tag, ".addr_l0"}, (reads.size() > 1) ? reads[1] : 34'h3_FFFF_FFFF, 64'(ea1));
    if (exp_lat >= 0) check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".addr_stable"}, 64'(stable_err), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  localparam logic [31:0] SATP = 32'h8000_0080;
  localparam logic [31:0] VA   = 32'h0040_1ABC;
  localparam logic [33:0] A_L1 = 34'h0_0008_0004;
  localparam logic [33:0] A_L0 = 34'h0_0008_1004;

  initial begin
    int          lat, n, bad, p0, s, d, elat;
    logic [31:0] satp, va, pte1;
    logic [33:0] a1, a0, e0, e1;
    logic [63:0] exp;

    rst_i = 1'b1; req_valid_i = 1'b0; req_vaddr_i = '0; satp_i = '0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0; mem_rsp_err_i = 1'b0;
    tick(); tick(); tick();

    // Reset state
    check("reset.req_ready", 64'(req_ready_o), 64'd1);
    check("reset.rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("reset.rsp_data", rsp_data_o, 64'd0);
    check("reset.mem_req_valid", 64'(mem_req_valid_o), 64'd0);
    check("reset.mem_req_addr", 64'(mem_req_addr_o), 64'd0);
    rst_i = 1'b0;
    tick();

    // Full 4 KiB walk, zero-wait memory
    mem.delete(); mem_err.delete();
    mem[A_L1] = 32'h0002_0401;
    mem[A_L0] = 32'h0003_00CF;
    walk_chk("full", SATP, VA, 64'h0000_0000_0003_00CF, 5, 2, A_L1, A_L0, 50, lat);

    // Superpage
    mem[A_L1] = 32'h2000_00CF;
    walk_chk("super", SATP, VA, 64'h0000_0001_2000_00CF, 3, 1, A_L1, '0, 50, lat);

    // Misaligned superpage and invalid L1 PTE
    mem[A_L1] = 32'h0000_04CF;
    walk_chk("misaligned", SATP, VA, 64'h0000_0002_0000_04CF, 3, 1, A_L1, '0, 50, lat);
    mem[A_L1] = 32'h0000_0000;
    walk_chk("l1_invalid", SATP, VA, 64'h0000_0002_0000_0000, 3, 1, A_L1, '0, 50, lat);

    // Pointer at level 0
    mem[A_L1] = 32'h0002_0401;
    mem[A_L0] = 32'h0000_0401;
    walk_chk("l0_pointer", SATP, VA, 64'h0000_0002_0000_0401, 5, 2, A_L1, A_L0, 50, lat);

    // Bus error on the level-0 read
    mem[A_L0] = 32'h1234_5678;
    mem_err[A_L0] = 1'b1;
    walk_chk("bus_err", SATP, VA, 64'h0000_0004_1234_5678, 5, 2, A_L1, A_L0, 50, lat);
    mem_err.delete();

    // Bare mode: page fault, no memory access, result within two cycles
    walk_chk("mode0", 32'h0000_0080, VA, 64'h0000_0002_0000_0000, -1, 0, '0, '0, 50, lat);
    check("mode0.latency_le2", 64'((lat >= 1) && (lat <= 2)), 64'd1);

    // Timeout on the level-1 read, then drain a late response
    mem[A_L0] = 32'h0003_00CF;
    rsp_budget = 0;
    walk_chk("timeout", SATP, VA, 64'h0000_0004_0000_0000, -1, 1, A_L1, '0, 400, lat);
    // 256 waiting cycles follow the handshake edge, then the pulse.
    check("timeout.cycles_after_hs", 64'(rsp_cyc - hs_first), 64'(TO + 1));
    bad = 0;
    for (int i = 0; i < 400 && cyc < hs_first + 300; i++) begin
      if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b0) bad++;
      tick();
    end
    if (req_ready_o !== 1'b0) bad++;
    check("drain.busy_until_late_rsp", 64'(bad), 64'd0);
    p0 = rsp_cnt;
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h0003_00CF; mem_rsp_err_i = 1'b0;
    tick();
    check("drain.idle_after_late_rsp", 64'(req_ready_o), 64'd1);
    tick();
    check("drain.late_rsp_no_pulse", 64'(rsp_cnt - p0), 64'd0);
    rsp_budget = 1000000;
    mem[A_L1] = 32'h0002_0401;
    walk_chk("after_drain", SATP, VA, 64'h0000_0000_0003_00CF, 5, 2, A_L1, A_L0, 50, lat);

    // Backpressure: ready low for 7 cycles on each request
    cfg_stall = 7;
    walk_chk("backpressure", SATP, VA, 64'h0000_0000_0003_00CF, 19, 2, A_L1, A_L0, 80, lat);
    cfg_stall = 0;

    // Reset while waiting for the level-0 response
    rsp_budget = 1;
    reads.delete(); stall_left = 0;
    req_valid_i = 1'b1; satp_i = SATP; req_vaddr_i = VA;
    tick();
    req_valid_i = 1'b0;
    for (int i = 0; i < 20 && reads.size() < 2; i++) tick();
    tick();
    check("rst.reached_l0_wait", 64'(reads.size()), 64'd2);
    rst_i = 1'b1;
    pend  = 0;
    tick();
    rst_i = 1'b0;
    check("rst.req_ready", 64'(req_ready_o), 64'd1);
    check("rst.rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst.rsp_data", rsp_data_o, 64'd0);
    check("rst.mem_req_valid", 64'(mem_req_valid_o), 64'd0);
    p0 = rsp_cnt;
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h0003_00CF; mem_rsp_err_i = 1'b0;
    tick(); tick(); tick(); tick();
    check("rst.stray_rsp_no_pulse", 64'(rsp_cnt - p0), 64'd0);
    check("rst.still_idle", 64'(req_ready_o), 64'd1);
    rsp_budget = 1000000;

    // Randomised walks against the reference model
    for (int t = 0; t < 40; t++) begin
      mem.delete(); mem_err.delete();
      satp = $urandom;
      satp[31] = ($urandom_range(0, 9) != 0);
      va   = $urandom;
      a1   = 34'(satp[21:0]) * 34'd4096 + 34'(va[31:22]) * 34'd4;
      pte1 = gen_pte();
      mem[a1] = pte1;
      if ($urandom_range(0, 7) == 0) mem_err[a1] = 1'b1;
      if (pte1[0] && (pte1[3:1] == 3'b000)) begin
        a0 = 34'(pte1[31:10]) * 34'd4096 + 34'(va[21:12]) * 34'd4;
        mem[a0] = gen_pte();
        if ($urandom_range(0, 7) == 0) mem_err[a0] = 1'b1;
      end
      s = $urandom_range(0, 2);
      d = $urandom_range(0, 2);
      cfg_stall = s;
      cfg_delay = d;
      exp  = ref_walk(satp, va, n, e0, e1);
      elat = (n > 0) ? n * (2 + s + d) + 1 : -1;
      walk_chk($sformatf("rand%0d", t), satp, va, exp, elat, n, e0, e1, 100, lat);
    end
    cfg_stall = 0;
    cfg_delay = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
